// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: mdop codes, FSM states and default latencies.
// Consumers: mdu (top) and mdu_calc. Optional accumulate support is controlled by MDU_MADD_EN.
package mdu_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_MADD  = 3'd7;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result datapath for mdu: product, quotient/remainder pair, or accumulate.
// The accumulate input and adder exist only when MDU_MADD_EN is defined.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
`ifdef MDU_MADD_EN
  input  logic [63:0] acc,
`endif
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [63:0] res,
  output logic        wr
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] udiv_b;
  logic [31:0] sdiv_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;

  assign prod_s = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
  assign prod_u = {32'd0, opa} * {32'd0, opb};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign mag_a  = opa[31] ? (~opa + 32'd1) : opa;
  assign mag_b  = opb[31] ? (~opb + 32'd1) : opb;
  assign udiv_b = (opb == 32'd0) ? 32'd1 : opb;
  assign sdiv_b = (mag_b == 32'd0) ? 32'd1 : mag_b;

  assign q_u   = opa / udiv_b;
  assign r_u   = opa % udiv_b;
  assign q_mag = mag_a / sdiv_b;
  assign r_mag = mag_a % sdiv_b;
  assign q_s   = (opa[31] ^ opb[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = opa[31] ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res = 64'd0;
    wr  = 1'b0;
    case (op)
      MD_MULT: begin
        res = prod_s;
        wr  = 1'b1;
      end
      MD_MULTU: begin
        res = prod_u;
        wr  = 1'b1;
      end
      MD_DIV: begin
        res = {r_s, q_s};
        wr  = (opb != 32'd0);
      end
      MD_DIVU: begin
        res = {r_u, q_u};
        wr  = (opb != 32'd0);
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        res = acc + prod_s;
        wr  = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO; busy stalls HI/LO consumers.
// Define MDU_MADD_EN to enable the madd (mdop 7) accumulate operation.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  mdop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         op_reg, op_next;
  logic [31:0]        a_reg, a_next;
  logic [31:0]        b_reg, b_next;
  logic [31:0]        hi_reg, hi_next;
  logic [31:0]        lo_reg, lo_next;

  logic               long_op;
  logic [63:0]        calc_res;
  logic               calc_wr;

  mdu_calc u_calc (
    .op   (op_reg),
`ifdef MDU_MADD_EN
    .acc  ({hi_reg, lo_reg}),
`endif
    .opa  (a_reg),
    .opb  (b_reg),
    .res  (calc_res),
    .wr   (calc_wr)
  );

  always_comb begin
    long_op = 1'b0;
    case (mdop)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: long_op = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (long_op) begin
            op_next    = mdop;
            a_next     = a;
            b_next     = b;
            cnt_next   = is_div_op(mdop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_next = ST_BUSY;
          end else if (mdop == MD_MTHI) begin
            hi_next = a;
          end else if (mdop == MD_MTLO) begin
            lo_next = a;
          end
        end
      end
      ST_BUSY: begin
        // start is deliberately not looked at here: a stray request must not disturb the op in flight.
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          if (calc_wr) begin
            hi_next = calc_res[63:32];
            lo_next = calc_res[31:0];
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= MD_NONE;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy = (state_reg == ST_BUSY);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
